hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline controller for the 5-stage RV32I datapath.
- Generates all stall/flush controls for the F/D/E/M/W pipeline registers and PC register.
- Generates operand-forwarding selects for the E-stage ALU inputs.
- Sequences a post-reset pipeline purge and a wait/timeout FSM for a variable-latency data memory.

Parameters:
- RESET_FLUSH_CYCLES, 4, cycles all stages are flushed after reset deasserts (>=1).
- MEM_TIMEOUT, 16, consecutive not-ready cycles before memory error lock (>=2).
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- Rs1D, Rs2D  in  5  source regs of instruction in D
- Rs1E, Rs2E, RdE  in  5  source/dest regs of instruction in E
- RdM, RdW  in  5  dest regs in M, W
- RegWriteM, RegWriteW  in  1  writeback enables in M, W
- ResultSrcE  in  2  result select in E (2'b01 = load)
- PCSrcE  in  1  taken branch/jump/jalr resolved in E
- MemReqM  in  1  load or store in M
- DMemReady  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM, StallW  out  1  hold PC / pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  clear register to bubble (control bits zero)
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = ResultW, 10 = ALUResultM
- MemErr  out  1  sticky data-memory timeout flag
- LoadUseStalls  out  CNT_W  count of load-use stall cycles

Behaviour:
- FSM states: PURGE, RUN, MEM_WAIT, ERR. Outputs combinational from state plus inputs; all state registered.
- reset=1 at an edge: state <= PURGE, purge counter <= RESET_FLUSH_CYCLES, wait counter <= 0, MemErr <= 0, LoadUseStalls <= 0.
- Reset mid-operation (any state, including ERR) has the identical effect.
- PURGE:
  - StallF=1; FlushD=FlushE=FlushM=FlushW=1; other stalls 0; forwards 00.
  - Counter decrements each cycle; when it reads 1, next state is RUN.
  - Gives exactly RESET_FLUSH_CYCLES cycles of purge after reset deasserts.
- Forwarding (RUN and MEM_WAIT):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00. M has priority over W.
  - ForwardBE is identical using Rs2E.
- Load-use (RUN only):
  - lw_stall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - Drives StallF=StallD=1 and FlushE=1 for one cycle.
  - LoadUseStalls increments by 1 per such cycle, wrapping at 2^CNT_W.
- Control hazard (RUN only):
  - PCSrcE=1 drives FlushD=FlushE=1, StallF=0.
  - PCSrcE and lw_stall are mutually exclusive: E holds either a load or a control transfer. If both are seen, PCSrcE wins and lw_stall is ignored, not counted.
- Memory wait:
  - In RUN, MemReqM & !DMemReady drives StallF=StallD=StallE=StallM=1 and FlushW=1 that same cycle.
  - The wait also suppresses lw_stall, the PCSrcE flushes and counting.
  - Next state is MEM_WAIT; wait counter <= 1.
- MEM_WAIT:
  - Same outputs as the memory-wait case while DMemReady=0; wait counter increments.
  - DMemReady=1: no stalls, outputs as RUN for that cycle (load-use/branch logic active), next state RUN, counter <= 0.
  - Wait counter reaching MEM_TIMEOUT with DMemReady=0: next state ERR, MemErr <= 1.
- ERR: all five stalls 1, all flushes 0, forwards 00. Held until reset.
- RUN with MemReqM & DMemReady: zero-wait access, no stall, stays RUN.
- Stall and flush are never both asserted on the same stage in any state.

Test Plan:
- Reset 1 cycle, then release with no hazards -> FlushD..W=1 and StallF=1 for exactly 4 cycles, then all stall/flush 0.
- add x5 in M, Rs1E=5, RegWriteM=1; also RdW=5, RegWriteW=1 -> ForwardAE=10. Repeat with RdM=0 -> ForwardAE=01. Rs1E=0 -> 00.
- Load in E (ResultSrcE=01, RdE=7), Rs2D=7 -> one cycle StallF=StallD=FlushE=1; LoadUseStalls 0->1. Same with RdE=0 -> no stall.
- PCSrcE=1 for one cycle -> FlushD=FlushE=1, StallF=0 that cycle only.
- MemReqM=1, DMemReady low 3 cycles then high -> StallF..StallM=1 and FlushW=1 for 3 cycles; 4th cycle all clear; state RUN. PCSrcE=1 during the wait -> no flush.
- MemReqM=1, DMemReady held 0 -> ERR entered after 16 wait cycles, MemErr=1, all stalls 1. Assert reset -> MemErr=0, PURGE sequence restarts.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Pipeline hazard bus between the RV32I datapath and its hazard controller.
// Latency: none, plain wires.
// Backpressure: the controller drives stall/flush back into the datapath.
//
// Ports (slave side = hazard_unit):
//   in : Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
//        ResultSrcE, PCSrcE, MemReqM, DMemReady
//   out: StallF..StallW, FlushD..FlushW, ForwardAE, ForwardBE, MemErr,
//        LoadUseStalls
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             DMemReady;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             StallW;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] LoadUseStalls;

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, DMemReady,
        output StallF, StallD, StallE, StallM, StallW,
        output FlushD, FlushE, FlushM, FlushW,
        output ForwardAE, ForwardBE, MemErr, LoadUseStalls
    );

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, DMemReady,
        input  StallF, StallD, StallE, StallM, StallW,
        input  FlushD, FlushE, FlushM, FlushW,
        input  ForwardAE, ForwardBE, MemErr, LoadUseStalls
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline, with post-reset purge and dmem wait/timeout FSM.
// Latency: all controls are combinational from current state + inputs; state updates on the next clk edge.
// Backpressure: a stalled data memory holds F..M and bubbles W; a timeout locks the pipe (all stalls) until reset.
//
// Ports: clk, reset (synchronous, active-high), hz (hazard_unit_if.slave: hazard inputs in, controls out).
module hazard_unit #(
    parameter int RESET_FLUSH_CYCLES = 4,
    parameter int MEM_TIMEOUT        = 16,
    parameter int CNT_W              = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);
    localparam int PW = $clog2(RESET_FLUSH_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {PURGE, RUN, MEM_WAIT, ERR} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    purge_cnt_q, purge_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       lw_stall;
    logic       mem_wait;
    logic       run_ctrl;
    logic       stall_f, stall_d, stall_e, stall_m, stall_w;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic [1:0] fwd_a_o, fwd_b_o;

    // M-stage result is younger than W, so it wins when both match.
    always_comb begin
        fwd_a = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)      fwd_a = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E) fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)      fwd_b = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E) fwd_b = 2'b01;
    end

    assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign mem_wait = hz.MemReqM && !hz.DMemReady;

    always_comb begin
        state_d     = state_q;
        purge_cnt_d = purge_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        lu_cnt_d    = lu_cnt_q;
        run_ctrl    = 1'b0;
        stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0; stall_w = 1'b0;
        flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;

        case (state_q)
            PURGE: begin
                stall_f = 1'b1;
                flush_d = 1'b1; flush_e = 1'b1; flush_m = 1'b1; flush_w = 1'b1;
                purge_cnt_d = purge_cnt_q - PW'(1);
                if (purge_cnt_q == PW'(1)) state_d = RUN;
            end
            RUN: begin
                fwd_a_o = fwd_a;
                fwd_b_o = fwd_b;
                if (mem_wait) begin
                    stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
                    flush_w = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WW'(1);
                end else begin
                    run_ctrl = 1'b1;
                end
            end
            MEM_WAIT: begin
                fwd_a_o = fwd_a;
                fwd_b_o = fwd_b;
                if (!hz.DMemReady) begin
                    stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
                    flush_w = 1'b1;
                    // Counter already holds the initial RUN-cycle miss, so
                    // the MEM_TIMEOUT-th consecutive miss trips the lock.
                    wait_cnt_d = wait_cnt_q + WW'(1);
                    if (wait_cnt_d == WW'(MEM_TIMEOUT)) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    run_ctrl   = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1; stall_w = 1'b1;
            end
            default: state_d = PURGE;
        endcase

        // Branch redirect and load-use are exclusive in E; a redirect
        // discards the stage anyway, so it takes precedence.
        if (run_ctrl) begin
            if (hz.PCSrcE) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                flush_e  = 1'b1;
                lu_cnt_d = lu_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PURGE;
            purge_cnt_q <= PW'(RESET_FLUSH_CYCLES);
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            lu_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            purge_cnt_q <= purge_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign hz.StallF        = stall_f;
    assign hz.StallD        = stall_d;
    assign hz.StallE        = stall_e;
    assign hz.StallM        = stall_m;
    assign hz.StallW        = stall_w;
    assign hz.FlushD        = flush_d;
    assign hz.FlushE        = flush_e;
    assign hz.FlushM        = flush_m;
    assign hz.FlushW        = flush_w;
    assign hz.ForwardAE     = fwd_a_o;
    assign hz.ForwardBE     = fwd_b_o;
    assign hz.MemErr        = mem_err_q;
    assign hz.LoadUseStalls = lu_cnt_q;
endmodule
